// File: rtl/d_memory_ctrl.sv
// Data memory for the load/store path: single-port RAM with valid/ready requests,
// byte-lane writes, a back-pressured registered read response and a clear sequencer.
module d_memory_ctrl #(
    parameter int unsigned       DATA_W = 16,
    parameter int unsigned       ADDR_W = 8,
    parameter logic [DATA_W-1:0] INIT0  = 16'h00AB,
    parameter logic [DATA_W-1:0] INIT1  = 16'h3C00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_start,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                busy_q;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                rd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NB-1:0]       wr_be;

    // A stalled response blocks new requests so rsp_rdata cannot be overwritten.
    assign req_ready = (state_q == StRun) && !(rsp_valid_q && !rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_en     = accept && !req_we;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_en      = 1'b0;
        wr_addr    = req_addr;
        wr_data    = req_wdata;
        wr_be      = req_be;
        unique case (state_q)
            StClear: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr_q;
                wr_be   = '1;
                if (clr_addr_q == '0) begin
                    wr_data = INIT0;
                end else if (clr_addr_q == ADDR_W'(1)) begin
                    wr_data = INIT1;
                end else begin
                    wr_data = '0;
                end
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == '1) begin
                    state_d    = StRun;
                    clr_addr_d = '0;
                end
            end
            StRun: begin
                wr_en = accept && req_we;
                if (clr_start) begin
                    state_d = StClear;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (rd_en) begin
            rsp_valid_d = 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StClear;
            clr_addr_q  <= '0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            busy_q      <= (state_d == StClear);
            rsp_valid_q <= rsp_valid_d;
            if (rd_en) begin
                rsp_rdata_q <= mem[req_addr];
            end
        end
    end

    // Storage array is intentionally not reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_d_memory_ctrl.sv
// Self-checking bench for d_memory_ctrl: read responses go through an expected-value
// queue popped on each response transfer; scenarios check control timing inline.
module tb_d_memory_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr_start;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        busy;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_q [$];

    d_memory_ctrl #(
        .DATA_W (16),
        .ADDR_W (8),
        .INIT0  (16'h00AB),
        .INIT1  (16'h3C00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every response transfer must match the oldest expected read value.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got rdata %h, expected no response",
                         rsp_rdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rsp_rdata !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_rdata: got %h, expected %h", rsp_rdata, e);
                end
            end
        end
    end

    // Entered and left at posedge+1; leaves the request accepted at the last edge.
    task automatic send(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input logic [15:0] exp);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (!we) exp_q.push_back(exp);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: req_ready %b, expected 1 within 100 cycles", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            if (req_ready !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_during_clear: got %b, expected 0", req_ready);
            end
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        int cnt;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, req_ready, rsp_valid, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_values: busy/ready/valid/rdata %b/%b/%b/%h, expected 1/0/0/0000",
                     busy, req_ready, rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(cnt);
        n_checks++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL reset_clear_len: got %0d cycles, expected 256", cnt);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_clear: got %b, expected 1", req_ready);
        end
        send(1'b0, 8'd0, 16'h0, 2'b00, 16'h00AB);
        send(1'b0, 8'd1, 16'h0, 2'b00, 16'h3C00);
        send(1'b0, 8'd2, 16'h0, 2'b00, 16'h0000);
        send(1'b0, 8'd255, 16'h0, 2'b00, 16'h0000);
        wait_drain("reset_contents");
    endtask

    task automatic test_write_read;
        send(1'b1, 8'h10, 16'hBEEF, 2'b11, 16'h0);
        send(1'b0, 8'h10, 16'h0, 2'b00, 16'hBEEF);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_latency: valid/rdata %b/%h, expected 1/beef", rsp_valid, rsp_rdata);
        end
        send(1'b1, 8'h10, 16'h1234, 2'b01, 16'h0);
        send(1'b0, 8'h10, 16'h0, 2'b11, 16'hBE34);
        send(1'b1, 8'h10, 16'hFFFF, 2'b00, 16'h0);
        send(1'b1, 8'h10, 16'h7700, 2'b10, 16'h0);
        send(1'b0, 8'h10, 16'h0, 2'b00, 16'h7734);
        wait_drain("write_read");
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_tab [3];
        exp_tab = '{16'h00AB, 16'h3C00, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'(i), 16'h0, 2'b00, exp_tab[i]);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL b2b_read%0d: valid/rdata %b/%h, expected 1/%h",
                         i, rsp_valid, rsp_rdata, exp_tab[i]);
            end
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        send(1'b0, 8'd0, 16'h0, 2'b00, 16'h00AB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 16'h00AB}) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: ready/valid/rdata %b/%b/%h, expected 0/1/00ab",
                         i, req_ready, rsp_valid, rsp_rdata);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid/ready %b/%b, expected 0/1", rsp_valid, req_ready);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_soft_clear;
        int cnt;
        send(1'b1, 8'd5, 16'h5555, 2'b11, 16'h0);
        send(1'b0, 8'd5, 16'h0, 2'b00, 16'h5555);
        wait_drain("pre_clear");
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        count_busy(cnt);
        n_checks++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL soft_clear_len: got %0d cycles, expected 256", cnt);
        end
        send(1'b0, 8'd5, 16'h0, 2'b00, 16'h0000);
        send(1'b0, 8'd0, 16'h0, 2'b00, 16'h00AB);
        wait_drain("soft_clear");
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        rsp_ready = 1'b0;
        send(1'b0, 8'd1, 16'h0, 2'b00, 16'h3C00);
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        repeat (99) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 16'h3C00) begin
            n_fail++;
            $display("FAIL rsp_kept_in_clear: busy/valid/rdata %b/%b/%h, expected 1/1/3c00",
                     busy, rsp_valid, rsp_rdata);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid/busy/ready %b/%b/%b, expected 0/1/0",
                     rsp_valid, busy, req_ready);
        end
        exp_q.delete();
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(cnt);
        n_checks++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL reclear_len: got %0d cycles, expected 256", cnt);
        end
        send(1'b0, 8'd1, 16'h0, 2'b00, 16'h3C00);
        send(1'b0, 8'd200, 16'h0, 2'b00, 16'h0000);
        wait_drain("reset_mid_clear");
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clr_start = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_soft_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/d_memory_ctrl.md
Name: d_memory_ctrl

Overview:
- Parametrised data memory for the CPU load/store path: a synchronous single-port RAM with a valid/ready request interface, byte-lane write enables, a registered read response with back-pressure, and a hardware clear sequencer.
- After reset, or on a soft-clear command, the sequencer walks the entire array. It writes the preset words at addresses 0 and 1 and zero everywhere else. Requests are refused until the sweep completes.

Parameters:
- DATA_W, 16, data word width; must be a multiple of 8.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- INIT0, 16'h00AB, value written to address 0 by the clear sequence (DATA_W bits).
- INIT1, 16'h3C00, value written to address 1 by the clear sequence (DATA_W bits).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr_start  in  1  soft-clear request; honoured only in RUN.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane enables; bit i gates bits [8i+7:8i].
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_W  read data.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Storage: reg array of DEPTH x DATA_W. The array itself is not reset; only the control registers are reset.
- States:
  - CLEAR: sequencer active.
  - RUN: requests serviced.
- Reset values: state = CLEAR, clr_addr = 0, busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0.
- CLEAR, each cycle:
  - Write mem[clr_addr]: INIT0 if clr_addr == 0, INIT1 if clr_addr == 1, else 0. All byte lanes are written.
  - clr_addr increments by 1.
  - On the cycle that writes address DEPTH-1, move to RUN and clear clr_addr to 0.
  - CLEAR therefore lasts exactly DEPTH cycles.
  - clr_start and req_valid are ignored in CLEAR.
- busy = (state == CLEAR), registered from state.
- req_ready = (state == RUN) && !(rsp_valid && !rsp_ready). It is combinational from state and the response registers.
- Accepted write: at the same edge, for each lane with req_be[i] = 1, update mem[req_addr] lane i from req_wdata. Lanes with req_be[i] = 0 are untouched. req_be = 0 is a legal no-op. No response is generated for a write.
- Accepted read:
  - At the edge: rsp_rdata <= full word mem[req_addr] (req_be ignored), rsp_valid <= 1.
  - Latency is 1 cycle: data is visible the cycle after acceptance.
- Response handshake:
  - rsp_valid && rsp_ready with no new read accepted: rsp_valid <= 0 and rsp_rdata holds.
  - rsp_valid && rsp_ready together with a newly accepted read: rsp_valid stays 1 and rsp_rdata updates. This gives back-to-back reads at one per cycle.
  - rsp_valid && !rsp_ready: req_ready = 0, and rsp_rdata and rsp_valid hold stable.
- Read after write to the same address on consecutive cycles returns the new data.
- clr_start in RUN:
  - If a request is also accepted that cycle, the request completes first (write performed, or read response registered).
  - State goes to CLEAR on the next edge.
  - A pending rsp_valid is preserved through CLEAR and is drained by rsp_ready as usual.
  - clr_start held high across repeated RUN entries retriggers a clear each time RUN is entered.
- Reset asserted mid-CLEAR or mid-transaction: control returns to reset values immediately (async). The sweep restarts from address 0 after rst_n deasserts. Any pending response is lost.
- Addresses wrap naturally at ADDR_W bits; no out-of-range case exists.

Test Plan:
- Reset deassert, idle inputs -> busy = 1 and req_ready = 0 for exactly 256 cycles, then busy = 0 and req_ready = 1. Reads return addr 0 = 16'h00AB, addr 1 = 16'h3C00, addr 2 = 0, addr 255 = 0.
- Write addr 8'h10 data 16'hBEEF be = 2'b11, then read 8'h10 -> rsp_valid one cycle after acceptance with 16'hBEEF. Then write 16'h1234 be = 2'b01 and read -> 16'hBE34.
- Back-to-back reads of 0, 1, 2 with rsp_ready = 1 -> rsp_valid high 3 consecutive cycles with 16'h00AB, 16'h3C00, 16'h0000.
- Read 0 with rsp_ready = 0 for 4 cycles -> req_ready = 0 and rsp_rdata = 16'h00AB stable. Raise rsp_ready -> one transfer, then req_ready = 1.
- After writing 16'h5555 to addr 5, pulse clr_start -> busy high 256 cycles. A subsequent read of 5 returns 0 and a read of 0 returns 16'h00AB.
- Assert rst_n low at clear cycle 100, release -> full 256-cycle CLEAR again. rsp_valid = 0 immediately on reset assertion.
